// File: rtl/audio_pkg.sv
// Shared encodings for the audio frame packer: channel modes, read FSM states
// and the default sample width.
package audio_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    CH_LEFT  = 2'd0,
    CH_RIGHT = 2'd1,
    CH_MEAN  = 2'd2
  } ch_mode_e;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

endpackage

// File: rtl/audio_pingpong_ram.sv
// Two-bank sample store: bank select is the address MSB; one write port and one
// read port with registered read data.
module audio_pingpong_ram
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W:0]       rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**(ADDR_W+1)];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/audio_frame_packer.sv
// Mono sample packer: channel select/mean, ping-pong frame buffering and a
// valid/ready frame streamer. Define AUDIO_PACK_PEAK_EN for per-frame peak output.
module audio_frame_packer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FRAME_LEN  = 1024,
  parameter int ADDR_W     = $clog2(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            ch_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_l_vld,
  input  logic                  in_r_vld,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           frame_cnt
`ifdef AUDIO_PACK_PEAK_EN
  ,
  output logic [DATA_WIDTH-1:0] peak_mag,
  output logic                  peak_vld
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   ISS_END   = (ADDR_W+1)'(FRAME_LEN);

  logic [1:0]            mode_q, mode_d, mode_eff;
  logic                  l_pend_q, l_pend_d;
  logic [DATA_WIDTH-1:0] l_hold_q, l_hold_d, l_val, smp_data;
  logic signed [DATA_WIDTH:0] mean_sum;
  logic                  smp_vld, wr_en, drop;
  logic                  wbank_q, wbank_d, rbank_q, rbank_d;
  logic [ADDR_W-1:0]     wptr_q, wptr_d;
  logic [1:0]            full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d, frame_cnt_q, frame_cnt_d;
  rd_state_e             state_q, state_d;
  logic [ADDR_W:0]       iss_cnt_q, iss_cnt_d;
  logic                  rd_pend_q, rd_pend_d, rd_last_q, rd_last_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d, sk_data_q, sk_data_d, ram_rdata;
  logic                  sk_vld_q, sk_vld_d, sk_last_q, sk_last_d;
  logic                  issue, pop, done;
  logic [1:0]            occ;

  // Channel mode follows ch_mode only until the first sample of a frame is taken.
  always_comb begin
    mode_eff = (wptr_q == '0 && !l_pend_q) ? ch_mode : mode_q;
    mode_d   = mode_eff;
    l_val    = in_l_vld ? in_data : l_hold_q;
    mean_sum = $signed({l_val[DATA_WIDTH-1], l_val}) + $signed({in_data[DATA_WIDTH-1], in_data});
    smp_vld  = 1'b0;
    smp_data = in_data;
    l_pend_d = l_pend_q;
    l_hold_d = l_hold_q;
    case (mode_eff)
      CH_RIGHT: smp_vld = in_r_vld;
      CH_MEAN: begin
        if (in_r_vld && (in_l_vld || l_pend_q)) begin
          smp_vld  = 1'b1;
          smp_data = DATA_WIDTH'(mean_sum >>> 1);
          l_pend_d = 1'b0;
        end else if (in_l_vld) begin
          l_pend_d = 1'b1;
          l_hold_d = in_data;
        end
      end
      default: smp_vld = in_l_vld;
    endcase
  end

  always_comb begin
    wr_en      = smp_vld && !full_q[wbank_q];
    drop       = smp_vld && full_q[wbank_q];
    full_d     = full_q;
    wbank_d    = wbank_q;
    wptr_d     = wptr_q;
    ovf_d      = drop;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    if (done) full_d[rbank_q] = 1'b0;
    if (wr_en) begin
      if (wptr_q == LAST_ADDR) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wptr_d          = '0;
      end else begin
        wptr_d = wptr_q + ADDR_W'(1);
      end
    end
  end

  // Output register plus one skid entry; reads are only issued when the word
  // in flight is guaranteed a slot, so occupancy never exceeds two.
  always_comb begin
    pop         = tvalid_q && m_tready;
    done        = pop && tlast_q;
    occ         = 2'(tvalid_q) + 2'(sk_vld_q) + 2'(rd_pend_q);
    issue       = (state_q != RD_IDLE) && (iss_cnt_q != ISS_END) && ((occ - 2'(pop)) < 2'd2);
    rd_pend_d   = issue;
    rd_last_d   = issue && (iss_cnt_q == (ADDR_W+1)'(FRAME_LEN - 1));
    iss_cnt_d   = issue ? iss_cnt_q + (ADDR_W+1)'(1) : iss_cnt_q;
    state_d     = state_q;
    rbank_d     = rbank_q;
    frame_cnt_d = done ? frame_cnt_q + 16'd1 : frame_cnt_q;
    case (state_q)
      RD_IDLE: begin
        iss_cnt_d = '0;
        if (full_q[rbank_q]) state_d = RD_FETCH;
      end
      RD_FETCH: state_d = RD_STREAM;
      RD_STREAM: begin
        if (done) begin
          state_d = RD_IDLE;
          rbank_d = ~rbank_q;
        end
      end
      default: state_d = RD_IDLE;
    endcase

    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    sk_vld_d  = sk_vld_q;
    sk_data_d = sk_data_q;
    sk_last_d = sk_last_q;
    if (!tvalid_q || pop) begin
      if (sk_vld_q) begin
        tvalid_d  = 1'b1;
        tdata_d   = sk_data_q;
        tlast_d   = sk_last_q;
        sk_vld_d  = rd_pend_q;
        sk_data_d = ram_rdata;
        sk_last_d = rd_last_q;
      end else begin
        tvalid_d = rd_pend_q;
        tlast_d  = rd_pend_q && rd_last_q;
        if (rd_pend_q) tdata_d = ram_rdata;
      end
    end else if (rd_pend_q) begin
      sk_vld_d  = 1'b1;
      sk_data_d = ram_rdata;
      sk_last_d = rd_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= '0;
      l_pend_q    <= 1'b0;
      l_hold_q    <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wptr_q      <= '0;
      full_q      <= '0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
      state_q     <= RD_IDLE;
      iss_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      sk_vld_q    <= 1'b0;
      sk_data_q   <= '0;
      sk_last_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      l_pend_q    <= l_pend_d;
      l_hold_q    <= l_hold_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wptr_q      <= wptr_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      iss_cnt_q   <= iss_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_last_q   <= rd_last_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      sk_vld_q    <= sk_vld_d;
      sk_data_q   <= sk_data_d;
      sk_last_q   <= sk_last_d;
    end
  end

  audio_pingpong_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr({wbank_q, wptr_q}),
    .wr_data(smp_data),
    .rd_en  (issue),
    .rd_addr({rbank_q, iss_cnt_q[ADDR_W-1:0]}),
    .rd_data(ram_rdata)
  );

  assign m_tdata   = tdata_q;
  assign m_tvalid  = tvalid_q;
  assign m_tlast   = tlast_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

`ifdef AUDIO_PACK_PEAK_EN
  logic [DATA_WIDTH-1:0] cur_peak_q, cur_peak_d, peak_mag_q, peak_mag_d, smp_abs, pk_max;
  logic                  peak_vld_q, peak_vld_d;

  // Most negative code has no positive twin, so its magnitude saturates.
  always_comb begin
    if (smp_data == {1'b1, {(DATA_WIDTH-1){1'b0}}}) smp_abs = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (smp_data[DATA_WIDTH-1])                smp_abs = -smp_data;
    else                                            smp_abs = smp_data;
    pk_max     = (smp_abs > cur_peak_q) ? smp_abs : cur_peak_q;
    cur_peak_d = cur_peak_q;
    peak_mag_d = peak_mag_q;
    peak_vld_d = 1'b0;
    if (wr_en) begin
      cur_peak_d = pk_max;
      if (wptr_q == LAST_ADDR) begin
        peak_mag_d = pk_max;
        peak_vld_d = 1'b1;
        cur_peak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_peak_q <= '0;
      peak_mag_q <= '0;
      peak_vld_q <= 1'b0;
    end else begin
      cur_peak_q <= cur_peak_d;
      peak_mag_q <= peak_mag_d;
      peak_vld_q <= peak_vld_d;
    end
  end

  assign peak_mag = peak_mag_q;
  assign peak_vld = peak_vld_q;
`endif

endmodule

// File: doc/audio_frame_packer.md
Name: audio_frame_packer

Overview:
- Sits directly downstream of the I2S receive stage; consumes the 16-bit ADC sample stream with its left/right valid strobes.
- Selects or mixes the channels into one mono sample, packs FRAME_LEN samples into frames in a ping-pong buffer, and streams each complete frame out over a valid/ready interface with a last marker.
- Feeds the FFT/FIR processing chain.
- Single clock domain: the I2S bit clock that also drives the receiver.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- FRAME_LEN, 1024, samples per frame; power of two, 4..4096.
- ADDR_W, $clog2(FRAME_LEN), derived; bank address width.

Ports:
- clk  in  1  I2S bit clock (sck domain); all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_mode  in  2  0=left, 1=right, 2=mean (L+R)>>>1, 3=reserved (treated as left); sampled once per frame start.
- in_data  in  DATA_WIDTH  sample from the I2S receiver.
- in_l_vld  in  1  one-cycle strobe: in_data is a left sample.
- in_r_vld  in  1  one-cycle strobe: in_data is a right sample.
- m_tdata  out  DATA_WIDTH  frame sample, two's complement.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  high on the final sample (index FRAME_LEN-1) of a frame.
- overflow  out  1  one-cycle pulse when a sample is dropped.
- drop_cnt  out  16  saturating count of dropped samples.
- frame_cnt  out  16  wrapping count of frames fully emitted.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; both banks empty; write bank 0; write pointer 0; read FSM IDLE.
- Input format: in_data is treated as two's complement. Mean mode sign-extends L and R by 1 bit, adds, then takes bits [DATA_WIDTH:1].
- Mono sample generation:
  - Left mode: write on in_l_vld.
  - Right mode: write on in_r_vld.
  - Mean mode: latch L on in_l_vld; write on the next in_r_vld. An R with no preceding L since the last write is ignored.
  - If in_l_vld and in_r_vld are both high in the same cycle, treat it as L then R: mean mode writes the pair; single-channel modes use their own strobe.
- Write side:
  - A mono sample is written to wbank[wptr] and wptr increments.
  - When wptr = FRAME_LEN-1 is written, mark the bank full, toggle wbank, clear wptr, and re-sample ch_mode.
  - If the bank about to be written is still full (reader behind), drop the sample, pulse overflow, increment drop_cnt (saturating at 0xFFFF), and leave wptr unchanged.
- Read FSM:
  - IDLE: when the oldest full bank exists, go to FETCH.
  - FETCH: issue RAM read of address 0 (1-cycle read latency); go to STREAM.
  - STREAM: m_tvalid=1. On m_tvalid&&m_tready, advance rptr and present the next word without a bubble; a one-entry prefetch/skid register is required.
  - At rptr = FRAME_LEN-1 with the handshake: m_tlast asserted with that beat; clear the bank's full flag the same cycle; increment frame_cnt; return to IDLE.
  - If the other bank is already full at that point, IDLE→FETCH follows; a 2-cycle gap between frames is allowed.
- AXI-stream rules: m_tdata, m_tlast and m_tvalid stay stable while m_tvalid && !m_tready. m_tvalid never depends combinationally on m_tready.
- Latency: first beat m_tvalid asserts 3 cycles after the write of the frame's last sample.
- Simultaneous events: the write to one bank and the read-completion of the other bank in the same cycle are both honoured. The full flag the writer sees is the registered value, so a freed bank accepts writes from the next cycle.
- Reset mid-frame: the partial frame is discarded, the output stream aborts (m_tvalid drops on the next cycle), and counters clear.
- Memory: two FRAME_LEN×DATA_WIDTH simple dual-port RAM banks (or one 2·FRAME_LEN RAM with the bank bit as the address MSB), synchronous read.

Optional Feature:
- Macro AUDIO_PACK_PEAK_EN.
- When defined:
  - Extra outputs peak_mag[DATA_WIDTH-1:0] and peak_vld.
  - Tracks the max |sample| per written frame; |−2^(DATA_WIDTH-1)| saturates to 2^(DATA_WIDTH-1)-1.
  - peak_vld pulses for 1 cycle when the bank is marked full; peak_mag holds until the next frame.
- When undefined: those ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package audio_pkg: ch_mode encodings (CH_LEFT, CH_RIGHT, CH_MEAN), read FSM state enum (RD_IDLE, RD_FETCH, RD_STREAM), default DATA_WIDTH.
- Sub-module audio_pingpong_ram: the two-bank synchronous dual-port RAM, one write port and one read port, registered read data.
- The top holds channel select, write control, read FSM/skid, and counters.

Test Plan:
- FRAME_LEN=8, mode 0, L=0..7 with R=0x7FFF interleaved, m_tready=1 → one frame of tdata 0..7, tlast on beat 8, frame_cnt=1, drop_cnt=0.
- Mode 2, L=0x7FFF with R=0x7FFF, then L=0x8000 with R=0x0000 → outputs 0x7FFF and 0xC000.
- m_tready=0 across 24 mono samples → 2 frames held in buffer; samples 17..24 dropped with overflow pulses, drop_cnt=8. Release ready → frames 0..7 then 8..15 emitted back-to-back.
- Random m_tready toggling (50%) over 10 frames → data order exact, tdata stable during stalls, frame_cnt=10.
- Assert rst mid-frame at beat 3 → m_tvalid=0 next cycle, counters 0; the next frame starts at the first post-reset sample.
- With AUDIO_PACK_PEAK_EN, frame containing −32768 and 1000 → peak_mag=0x7FFF, peak_vld single pulse.
